// File: rtl/bus_ctrl_pkg.sv
// bus_ctrl_pkg: shared encodings for the register-bus sequencer and the
// future instruction decoder.
//   - op codes       : OP_NOP, OP_MOVE, OP_CLEAR (3 is reserved/illegal)
//   - source codes   : SRC_IMM, SRC_REG1, SRC_REG2 (3 is reserved/illegal)
//   - dst mask bits  : DST_REG1, DST_REG2
//   - xfer_state_t   : sequencer FSM states
package bus_ctrl_pkg;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_MOVE  = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;

  localparam logic [1:0] SRC_IMM  = 2'd0;
  localparam logic [1:0] SRC_REG1 = 2'd1;
  localparam logic [1:0] SRC_REG2 = 2'd2;

  localparam int unsigned DST_REG1 = 0;
  localparam int unsigned DST_REG2 = 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    RELEASE,
    CLR,
    ERR
  } xfer_state_t;

endpackage

// File: rtl/bus_cmd_check.sv
// bus_cmd_check: combinational legality check of a bus transfer command.
// Ports:
//   op    in  2  operation code
//   src   in  2  MOVE source code
//   dst   in  2  destination mask
//   legal out 1  command may be executed
module bus_cmd_check
  import bus_ctrl_pkg::*;
(
  input  logic [1:0] op,
  input  logic [1:0] src,
  input  logic [1:0] dst,
  output logic       legal
);

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_NOP:   legal = 1'b1;
      // A register may not be both driver and loader in the same transfer.
      OP_MOVE:  legal = (src != 2'd3) && (dst != '0)
                        && !((src == SRC_REG1) && dst[DST_REG1])
                        && !((src == SRC_REG2) && dst[DST_REG2]);
      OP_CLEAR: legal = (dst != '0);
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/bus_xfer_sequencer.sv
// bus_xfer_sequencer: initiator of the shared register bus. Accepts one
// command at a time (valid/ready) and produces a setup/transfer/release
// strobe sequence for reg1/reg2 plus its own immediate bus drive.
// Ports:
//   clk, reset (sync, active-low)
//   cmd_valid/cmd_ready, cmd_op, cmd_src, cmd_dst, cmd_imm : command port
//   bus (inout), bus_drive                                 : immediate drive
//   reg1_/reg2_ data_in, data_out, clr                     : register strobes
//   done, err                                              : completion pulses
// Configuration macro: BUS_XFER_TURNAROUND_EN adds the RELEASE cycle after
// XFER (4-cycle MOVE); without it XFER returns straight to IDLE and carries
// the done pulse (3-cycle MOVE).
module bus_xfer_sequencer
  import bus_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [1:0]        cmd_src,
  input  logic [1:0]        cmd_dst,
  input  logic [DATA_W-1:0] cmd_imm,
  inout  wire logic [DATA_W-1:0] bus,
  output logic              bus_drive,
  output logic              reg1_data_in,
  output logic              reg1_data_out,
  output logic              reg1_clr,
  output logic              reg2_data_in,
  output logic              reg2_data_out,
  output logic              reg2_clr,
  output logic              done,
  output logic              err
);

`ifdef BUS_XFER_TURNAROUND_EN
  localparam bit TURNAROUND = 1'b1;
`else
  localparam bit TURNAROUND = 1'b0;
`endif

  xfer_state_t state, state_next;

  logic [1:0]        src_q, dst_q;
  logic [DATA_W-1:0] imm_q;
  logic              accept, legal;
  logic [1:0]        src_sel, dst_sel;
  logic              src_en;

  logic drive_n, r1_in_n, r1_out_n, r1_clr_n;
  logic r2_in_n, r2_out_n, r2_clr_n, done_n, err_n;

  assign cmd_ready = (state == IDLE) && reset;
  assign accept    = cmd_valid && cmd_ready;

  bus_cmd_check u_check (
    .op    (cmd_op),
    .src   (cmd_src),
    .dst   (cmd_dst),
    .legal (legal)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!legal) begin
            state_next = ERR;
          end else begin
            case (cmd_op)
              OP_MOVE:  state_next = SETUP;
              OP_CLEAR: state_next = CLR;
              // NOP borrows RELEASE: a strobe-free cycle that carries done.
              default:  state_next = RELEASE;
            endcase
          end
        end
      end
      SETUP:   state_next = XFER;
      XFER:    state_next = TURNAROUND ? RELEASE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered. On
  // the accept edge the command latch is not yet loaded, so the live command
  // fields are used instead.
  always_comb begin
    src_sel  = accept ? cmd_src : src_q;
    dst_sel  = accept ? cmd_dst : dst_q;
    src_en   = (state_next == SETUP) || (state_next == XFER);
    drive_n  = src_en && (src_sel == SRC_IMM);
    r1_out_n = src_en && (src_sel == SRC_REG1);
    r2_out_n = src_en && (src_sel == SRC_REG2);
    r1_in_n  = (state_next == XFER) && dst_sel[DST_REG1];
    r2_in_n  = (state_next == XFER) && dst_sel[DST_REG2];
    r1_clr_n = (state_next == CLR) && dst_sel[DST_REG1];
    r2_clr_n = (state_next == CLR) && dst_sel[DST_REG2];
    done_n   = (state_next == RELEASE) || (state_next == CLR)
               || (!TURNAROUND && (state_next == XFER));
    err_n    = (state_next == ERR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      imm_q         <= '0;
      bus_drive     <= 1'b0;
      reg1_data_in  <= 1'b0;
      reg1_data_out <= 1'b0;
      reg1_clr      <= 1'b0;
      reg2_data_in  <= 1'b0;
      reg2_data_out <= 1'b0;
      reg2_clr      <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_next;
      bus_drive     <= drive_n;
      reg1_data_in  <= r1_in_n;
      reg1_data_out <= r1_out_n;
      reg1_clr      <= r1_clr_n;
      reg2_data_in  <= r2_in_n;
      reg2_data_out <= r2_out_n;
      reg2_clr      <= r2_clr_n;
      done          <= done_n;
      err           <= err_n;
      if (accept) begin
        src_q <= cmd_src;
        dst_q <= cmd_dst;
        imm_q <= cmd_imm;
      end
    end
  end

  assign bus = bus_drive ? imm_q : 'z;

endmodule
